// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared widths and types for the 16-bit datapath register file.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_ADDR_W = 4;
    localparam int NUM_REGS       = 2 ** DEFAULT_ADDR_W;

    typedef logic [DEFAULT_DATA_W-1:0] data_t;
    typedef logic [DEFAULT_ADDR_W-1:0] addr_t;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/reg_file_rd_port.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_rd_port
//  Description : Combinational read port: storage mux plus optional forwarding
//                of the in-flight write data.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W = regfile_pkg::DEFAULT_DATA_W,
    parameter int ADDR_W = regfile_pkg::DEFAULT_ADDR_W,
    parameter int BYPASS = 0
) (
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_wr_en,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_mem [2**ADDR_W],
    output logic [DATA_W-1:0] o_rd_data
);

    logic              w_hit;
    logic [DATA_W-1:0] w_stored;

    // A write held off by reset never lands, so it must not be forwarded either.
    assign w_hit    = i_wr_en && i_rst_n && (i_rd_addr == i_wr_addr);
    assign w_stored = i_mem[i_rd_addr];

    always_comb begin
        o_rd_data = w_stored;
        if ((BYPASS != 0) && w_hit) begin
            o_rd_data = i_wr_data;
        end
    end

endmodule : reg_file_rd_port
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file
//  Description : 2-read / 1-write general-purpose register file; reads are
//                combinational, the write lands on the rising clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file
    import regfile_pkg::*;
#(
    parameter int DATA_W = regfile_pkg::DEFAULT_DATA_W,
    parameter int ADDR_W = regfile_pkg::DEFAULT_ADDR_W,
    parameter int BYPASS = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    input  logic [DATA_W-1:0] C,
    input  logic [ADDR_W-1:0] Aaddr,
    input  logic [ADDR_W-1:0] Baddr,
    input  logic [ADDR_W-1:0] Caddr,
    input  logic              Load
);

    localparam int c_NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem_q [c_NUM_REGS];
    logic [DATA_W-1:0] w_mem_d [c_NUM_REGS];

    always_comb begin
        for (int i = 0; i < c_NUM_REGS; i++) begin
            w_mem_d[i] = r_mem_q[i];
            if (Load && (Caddr == ADDR_W'(i))) begin
                w_mem_d[i] = C;
            end
        end
    end

    // Reset outranks Load, so a write in a reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_mem_q[i] <= w_mem_d[i];
            end
        end
    end

    reg_file_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_rd_a (
        .i_rd_addr (Aaddr),
        .i_wr_addr (Caddr),
        .i_wr_data (C),
        .i_wr_en   (Load),
        .i_rst_n   (rst_n),
        .i_mem     (r_mem_q),
        .o_rd_data (A)
    );

    reg_file_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_rd_b (
        .i_rd_addr (Baddr),
        .i_wr_addr (Caddr),
        .i_wr_data (C),
        .i_wr_en   (Load),
        .i_rst_n   (rst_n),
        .i_mem     (r_mem_q),
        .o_rd_data (B)
    );

endmodule : reg_file
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_file
//  Description : Directed self-checking bench for reg_file, run with BYPASS=0
//                and BYPASS=1 instances sharing one stimulus stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file;
    import regfile_pkg::*;

    logic  clk;
    logic  rst_n;
    data_t c_in;
    addr_t a_addr;
    addr_t b_addr;
    addr_t c_addr;
    logic  load;
    data_t a0, b0, a1, b1;

    int n_checks = 0;
    int n_fail   = 0;

    reg_file #(.DATA_W(16), .ADDR_W(4), .BYPASS(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (a0),
        .B     (b0),
        .C     (c_in),
        .Aaddr (a_addr),
        .Baddr (b_addr),
        .Caddr (c_addr),
        .Load  (load)
    );

    reg_file #(.DATA_W(16), .ADDR_W(4), .BYPASS(1)) dut_byp (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (a1),
        .B     (b1),
        .C     (c_in),
        .Aaddr (a_addr),
        .Baddr (b_addr),
        .Caddr (c_addr),
        .Load  (load)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input data_t obs, input data_t exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        data_t exp_v;

        // Reset held for two edges with a write pending
        rst_n  = 1'b0;
        load   = 1'b1;
        c_addr = 4'd1;
        c_in   = 16'hFFFF;
        a_addr = 4'd1;
        b_addr = 4'd2;
        tick();
        tick();
        rst_n = 1'b1;
        load  = 1'b0;
        #1;
        check("reset_a",     a0, 16'h0000);
        check("reset_b",     b0, 16'h0000);
        check("reset_a_byp", a1, 16'h0000);
        check("reset_b_byp", b1, 16'h0000);

        // Basic write / read
        c_in = 16'h0001;
        load = 1'b1;
        tick();
        load = 1'b0;
        #1;
        check("basic_a", a0, 16'h0001);
        check("basic_b", b0, 16'h0000);
        c_in = 16'h1234;
        tick();
        check("noload_a",     a0, 16'h0001);
        check("noload_a_byp", a1, 16'h0001);

        // Full sweep
        load = 1'b1;
        for (int i = 0; i < 16; i++) begin
            c_addr = 4'(i);
            c_in   = 16'hA000 + 16'(i);
            tick();
        end
        load = 1'b0;
        for (int i = 0; i < 16; i++) begin
            a_addr = 4'(i);
            b_addr = 4'(15 - i);
            #1;
            check("sweep_a",     a0, 16'hA000 + 16'(i));
            check("sweep_b",     b0, 16'hA00F - 16'(i));
            check("sweep_a_byp", a1, 16'hA000 + 16'(i));
            check("sweep_b_byp", b1, 16'hA00F - 16'(i));
        end

        // Read during write to the same address
        c_addr = 4'd3;
        c_in   = 16'h0055;
        load   = 1'b1;
        tick();
        c_in   = 16'h00AA;
        a_addr = 4'd3;
        b_addr = 4'd4;
        #1;
        check("rdw_pre_a",     a0, 16'h0055);
        check("rdw_pre_a_byp", a1, 16'h00AA);
        check("rdw_pre_b_byp", b1, 16'hA004);
        tick();
        load = 1'b0;
        #1;
        check("rdw_post_a",     a0, 16'h00AA);
        check("rdw_post_a_byp", a1, 16'h00AA);

        // Back-to-back overwrite, both ports on the same register
        c_addr = 4'd5;
        a_addr = 4'd5;
        b_addr = 4'd5;
        load   = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            c_in = 16'(k);
            tick();
            check("b2b_a", a0, 16'(k));
            check("b2b_b", b0, 16'(k));
        end
        load = 1'b0;
        #1;
        check("b2b_final_a_byp", a1, 16'h0003);

        // Mid-operation reset with a write pending; no forwarding in reset
        rst_n  = 1'b0;
        load   = 1'b1;
        c_addr = 4'd3;
        c_in   = 16'hBEEF;
        a_addr = 4'd3;
        #1;
        check("rst_nobyp_a",     a0, 16'h00AA);
        check("rst_nobyp_a_byp", a1, 16'h00AA);
        tick();
        rst_n = 1'b1;
        load  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            a_addr = 4'(i);
            b_addr = 4'(15 - i);
            #1;
            check("midrst_a",     a0, 16'h0000);
            check("midrst_b",     b0, 16'h0000);
            check("midrst_a_byp", a1, 16'h0000);
        end

        // Writes resume after reset release
        load   = 1'b1;
        c_addr = 4'd7;
        c_in   = 16'h7777;
        a_addr = 4'd7;
        b_addr = 4'd3;
        tick();
        load = 1'b0;
        #1;
        exp_v = 16'h7777;
        check("resume_a",     a0, exp_v);
        check("resume_b",     b0, 16'h0000);
        check("resume_a_byp", a1, exp_v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_reg_file
`default_nettype wire
